// File: rtl/branch_target_buffer_if.sv
// Branch target buffer access interface.
// Groups the fetch-side lookup port, the EX-side resolution/update port and the
// whole-table invalidate control into one bundle.
//   master : fetch/EX/control side (drives keys, updates, clear; sees prediction, busy)
//   slave  : the branch target buffer itself
interface branch_target_buffer_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] read_key;   // fetch PC to look up
    logic [ADDR_WIDTH-1:0] read_val;   // predicted target, 0 when not predicting taken
    logic                  read_valid; // predict taken
    logic                  write;      // resolved branch update strobe
    logic [ADDR_WIDTH-1:0] write_key;  // PC of the resolved branch
    logic [ADDR_WIDTH-1:0] write_val;  // resolved target
    logic                  hit;        // 1 = resolved taken
    logic                  clear;      // start whole-table invalidate
    logic                  busy;       // invalidate sweep in progress

    modport master (
        output read_key, write, write_key, write_val, hit, clear,
        input  read_val, read_valid, busy
    );

    modport slave (
        input  read_key, write, write_key, write_val, hit, clear,
        output read_val, read_valid, busy
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : branch_target_buffer_if slave modport
//           read_key -> read_val/read_valid is a zero-latency combinational lookup;
//           write/write_key/write_val/hit train the table at the clock edge;
//           clear starts an ENTRIES-cycle invalidate sweep reported on busy.
module branch_target_buffer #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ENTRIES    = 16,
    localparam int unsigned IDX_BITS  = $clog2(ENTRIES)
) (
    input logic                    clk,
    input logic                    reset,
    branch_target_buffer_if.slave  bus
);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ENTRIES - 1);

    typedef enum logic {StIdle, StClear} state_e;

    state_e               state_q, state_d;
    logic [IDX_BITS-1:0]  clr_idx_q, clr_idx_d;

    logic                 valid_q  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];

    // Key split
    logic [IDX_BITS-1:0] r_idx, w_idx;
    logic [TAG_W-1:0]    r_tag, w_tag;

    assign r_idx = bus.read_key[IDX_BITS-1:0];
    assign r_tag = bus.read_key[ADDR_WIDTH-1:IDX_BITS];
    assign w_idx = bus.write_key[IDX_BITS-1:0];
    assign w_tag = bus.write_key[ADDR_WIDTH-1:IDX_BITS];

    // Read path: pre-edge contents, no bypass from a same-cycle write
    logic r_match;
    assign r_match        = (state_q == StIdle) && valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign bus.read_valid = r_match && ctr_q[r_idx][1];
    assign bus.read_val   = bus.read_valid ? target_q[r_idx] : '0;
    assign bus.busy       = (state_q == StClear);

    // Update path decode; clear in the same cycle wins over a write
    logic       upd_en;
    logic       w_match;
    logic [1:0] w_ctr;
    logic [1:0] w_ctr_inc, w_ctr_dec;

    assign upd_en    = (state_q == StIdle) && bus.write && !bus.clear;
    assign w_match   = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign w_ctr     = ctr_q[w_idx];
    assign w_ctr_inc = (w_ctr == 2'b11) ? 2'b11 : w_ctr + 2'b01;
    assign w_ctr_dec = (w_ctr == 2'b00) ? 2'b00 : w_ctr - 2'b01;

    // Clear FSM next state
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clear) begin
                    state_d   = StClear;
                    clr_idx_d = '0;
                end
            end
            StClear: begin
                if (bus.clear) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == LAST_IDX) begin
                    state_d   = StIdle;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Table storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (state_q == StClear) begin
            // Targets are left as-is; valid=0 makes them unreachable
            valid_q[clr_idx_q] <= 1'b0;
            ctr_q[clr_idx_q]   <= 2'b01;
        end else if (upd_en) begin
            if (w_match) begin
                if (bus.hit) begin
                    ctr_q[w_idx]    <= w_ctr_inc;
                    target_q[w_idx] <= bus.write_val;
                end else begin
                    ctr_q[w_idx]    <= w_ctr_dec;
                end
            end else if (bus.hit) begin
                // Only taken branches allocate; entry starts weakly taken
                valid_q[w_idx]  <= 1'b1;
                tag_q[w_idx]    <= w_tag;
                target_q[w_idx] <= bus.write_val;
                ctr_q[w_idx]    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural table model.
module tb_branch_target_buffer;
    localparam int AW = 16;
    localparam int N  = 16;

    logic clk;
    logic reset;

    branch_target_buffer_if #(.ADDR_WIDTH(AW)) bus ();

    branch_target_buffer #(
        .ADDR_WIDTH (AW),
        .ENTRIES    (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks;
    int failures;

    // Behavioural model: one record per index, counter as plain integer 0..3,
    // clear sweep as "cycles remaining".
    bit m_valid  [N];
    int m_tag    [N];
    int m_target [N];
    int m_ctr    [N];
    int m_clear_left;
    bit cmp_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_ctr[i]    = 1;
        end
        m_clear_left = 0;
    endtask

    task automatic model_edge();
        int idx;
        int tg;
        if (m_clear_left > 0) begin
            idx = N - m_clear_left;
            m_valid[idx] = 1'b0;
            m_ctr[idx]   = 1;
            m_clear_left = bus.clear ? N : m_clear_left - 1;
        end else if (bus.clear) begin
            m_clear_left = N;
        end else if (bus.write) begin
            idx = int'(bus.write_key) % N;
            tg  = int'(bus.write_key) / N;
            if (m_valid[idx] && m_tag[idx] == tg) begin
                if (bus.hit) begin
                    m_ctr[idx]    = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    m_target[idx] = int'(bus.write_val);
                end else begin
                    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (bus.hit) begin
                m_valid[idx]  = 1'b1;
                m_tag[idx]    = tg;
                m_target[idx] = int'(bus.write_val);
                m_ctr[idx]    = 2;
            end
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        int idx;
        int tg;
        bit exp_rv;
        int exp_val;
        if (cmp_en) begin
            idx     = int'(bus.read_key) % N;
            tg      = int'(bus.read_key) / N;
            exp_rv  = (m_clear_left == 0) && m_valid[idx] && (m_tag[idx] == tg)
                      && (m_ctr[idx] >= 2);
            exp_val = exp_rv ? m_target[idx] : 0;
            chk("model_read_valid", 32'(bus.read_valid), 32'(exp_rv));
            chk("model_read_val", 32'(bus.read_val), 32'(exp_val));
            chk("model_busy", 32'(bus.busy), 32'(m_clear_left > 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        if (reset) model_edge();
        #1;
    endtask

    task automatic upd(input logic [15:0] key, input logic [15:0] val, input logic h);
        bus.write     = 1'b1;
        bus.write_key = key;
        bus.write_val = val;
        bus.hit       = h;
        tick();
        bus.write     = 1'b0;
    endtask

    task automatic look(input string name, input logic [15:0] key,
                        input logic exp_rv, input logic [15:0] exp_val);
        bus.read_key = key;
        #1;
        chk({name, "_valid"}, 32'(bus.read_valid), 32'(exp_rv));
        chk({name, "_val"}, 32'(bus.read_val), 32'(exp_val));
    endtask

    initial begin
        int n;
        checks       = 0;
        failures     = 0;
        cmp_en       = 1'b0;
        reset        = 1'b0;
        bus.read_key  = '0;
        bus.write     = 1'b0;
        bus.write_key = '0;
        bus.write_val = '0;
        bus.hit       = 1'b0;
        bus.clear     = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        #22 reset = 1'b1;
        tick();

        // 1. Post-reset lookup
        look("s1_lookup", 16'h0005, 1'b0, 16'h0000);
        chk("s1_busy", 32'(bus.busy), 32'd0);

        // 2. Allocate; same-cycle read sees pre-edge contents
        bus.write = 1'b1; bus.write_key = 16'h0013; bus.write_val = 16'h0040; bus.hit = 1'b1;
        look("s2_same_cycle", 16'h0013, 1'b0, 16'h0000);
        tick();
        bus.write = 1'b0;
        look("s2_after", 16'h0013, 1'b1, 16'h0040);

        // 3. Counter saturation (ctr starts at weak-T)
        upd(16'h0013, 16'h0040, 1'b0);
        look("s3_nt_once", 16'h0013, 1'b0, 16'h0000);
        upd(16'h0013, 16'h0040, 1'b1);
        upd(16'h0013, 16'h0040, 1'b1);
        look("s3_strong_t", 16'h0013, 1'b1, 16'h0040);
        upd(16'h0013, 16'h0040, 1'b1);
        upd(16'h0013, 16'h0040, 1'b0);
        look("s3_sat_high", 16'h0013, 1'b1, 16'h0040);
        for (int i = 0; i < 3; i++) upd(16'h0013, 16'h0040, 1'b0);
        look("s3_strong_nt", 16'h0013, 1'b0, 16'h0000);
        upd(16'h0013, 16'h0040, 1'b1);
        look("s3_weak_nt", 16'h0013, 1'b0, 16'h0000);
        upd(16'h0013, 16'h0040, 1'b1);
        look("s3_sat_low", 16'h0013, 1'b1, 16'h0040);

        // 4. Alias replacement
        look("s4_alias_miss", 16'h0023, 1'b0, 16'h0000);
        upd(16'h0023, 16'h0080, 1'b1);
        look("s4_new", 16'h0023, 1'b1, 16'h0080);
        look("s4_evicted", 16'h0013, 1'b0, 16'h0000);
        upd(16'h0033, 16'h0099, 1'b0);
        look("s4_nt_no_alloc", 16'h0023, 1'b1, 16'h0080);

        // 5. Clear sweep
        for (int k = 0; k < N; k++) upd(16'(k), 16'(16'h0100 + k), 1'b1);
        look("s5_populated", 16'h0007, 1'b1, 16'h0107);
        bus.clear = 1'b1;
        bus.write = 1'b1; bus.write_key = 16'h0001; bus.write_val = 16'h0555; bus.hit = 1'b1;
        tick();
        bus.clear = 1'b0;
        n = 0;
        while (bus.busy && n < 40) begin
            bus.read_key  = 16'(n % N);
            bus.write     = 1'b1;
            bus.write_key = 16'(16'h0020 + n % N);
            bus.write_val = 16'h0777;
            bus.hit       = 1'b1;
            #1;
            chk("s5_rv_during_sweep", 32'(bus.read_valid), 32'd0);
            n++;
            tick();
        end
        bus.write = 1'b0;
        chk("s5_busy_cycles", 32'(n), 32'd16);
        for (int k = 0; k < N; k++) begin
            look("s5_post_miss", 16'(k), 1'b0, 16'h0000);
            look("s5_mid_write_miss", 16'(16'h0020 + k), 1'b0, 16'h0000);
        end

        // 6. Async reset mid-clear
        for (int k = 0; k < N; k++) upd(16'(k), 16'(16'h0200 + k), 1'b1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.read_key = 16'h000A;
        #2;
        chk("s6_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        model_reset();
        #1;
        chk("s6_busy_async", 32'(bus.busy), 32'd0);
        chk("s6_rv_async", 32'(bus.read_valid), 32'd0);
        tick();
        tick();
        #2 reset = 1'b1;
        tick();
        chk("s6_idle", 32'(bus.busy), 32'd0);
        bus.write = 1'b1; bus.write_key = 16'h0013; bus.write_val = 16'h0040; bus.hit = 1'b1;
        look("s6_same_cycle", 16'h0013, 1'b0, 16'h0000);
        tick();
        bus.write = 1'b0;
        look("s6_alloc", 16'h0013, 1'b1, 16'h0040);
        look("s6_other_cleared", 16'h000A, 1'b0, 16'h0000);

        // Randomized phase: small key space so tags alias often
        for (int c = 0; c < 3000; c++) begin
            bus.read_key  = 16'($urandom_range(0, 63));
            bus.write     = 1'($urandom_range(0, 1));
            bus.write_key = 16'($urandom_range(0, 63));
            bus.write_val = 16'($urandom);
            bus.hit       = 1'($urandom_range(0, 2) != 0);
            bus.clear     = ($urandom_range(0, 149) == 0);
            tick();
        end
        bus.write = 1'b0;
        bus.clear = 1'b0;
        tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Fetch-side branch target buffer with 2-bit direction predictors.
- Fetch drives the read port with the current PC and gets a predicted target plus a take/no-take flag in the same cycle.
- The EX-stage branch resolution logic drives the write port with the resolved PC, resolved target and the actual outcome, training the table.
- Also supports a multi-cycle whole-table invalidate sequence, used on context or program change.

Parameters:
ADDR_WIDTH, 16, width of PC/instruction addresses.
ENTRIES, 16, number of direct-mapped entries; power of two, >= 2.
IDX_BITS, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
read_key  input  ADDR_WIDTH  fetch PC to look up.
read_val  output  ADDR_WIDTH  predicted target; 0 when read_valid=0.
read_valid  output  1  predict taken, redirect fetch to read_val.
write  input  1  resolved branch update strobe; one update per asserted cycle.
write_key  input  ADDR_WIDTH  PC of the resolved branch.
write_val  input  ADDR_WIDTH  resolved target address.
hit  input  1  1 = branch resolved taken, 0 = not taken.
clear  input  1  start whole-table invalidate; single-cycle pulse is sufficient.
busy  output  1  invalidate sequence in progress.

Behaviour:
- Key split:
  - index = key[IDX_BITS-1:0].
  - tag = key[ADDR_WIDTH-1:IDX_BITS].
- Entry contents: valid, tag, target[ADDR_WIDTH], ctr[1:0].
  - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (reset=0, async):
  - All entries: valid=0, target=0, ctr=01.
  - State=IDLE, clear index=0.
  - Outputs: read_valid=0, read_val=0, busy=0.
  - Asserting reset mid-clear aborts the sweep immediately.
- Read path (combinational, zero latency):
  - match = state==IDLE & valid[idx] & tag[idx]==read_tag.
  - read_valid = match & ctr[idx][1].
  - read_val = read_valid ? target[idx] : 0.
  - read_valid is 0 whenever busy=1.
- Update path (applied at the clock edge where write=1 and state==IDLE):
  - Tag hit (valid & tag match), hit=1: ctr saturating +1 (11 stays 11); target <= write_val.
  - Tag hit, hit=0: ctr saturating -1 (00 stays 00); target unchanged.
  - Tag miss, hit=1: allocate/replace the entry; valid=1, tag=write tag, target=write_val, ctr=10.
  - Tag miss, hit=0: no change; not-taken branches are never allocated.
- Read and write on the same index in the same cycle: the read returns pre-edge contents. There is no bypass.
- Clear FSM, state IDLE:
  - clear=1 -> CLEAR with clr_idx=0 at the next edge.
  - A write in that same cycle is dropped; clear has priority.
- Clear FSM, state CLEAR:
  - Each cycle: valid[clr_idx]=0, ctr[clr_idx]=01, then clr_idx+1.
  - After clearing entry ENTRIES-1 -> IDLE.
  - busy=1 for exactly ENTRIES cycles.
  - Writes are ignored during CLEAR.
  - clear=1 while in CLEAR restarts the sweep at clr_idx=0.
- Targets are not cleared by the sweep. They are unreachable because valid=0.
- No arithmetic beyond the 2-bit saturating counter and the IDX_BITS clear counter. The clear counter does not wrap: it leaves CLEAR at ENTRIES-1.

Test Plan:
(All with ENTRIES=16, ADDR_WIDTH=16.)
1. Post-reset lookup:
   - Release reset; read_key=0x0005 -> read_valid=0, read_val=0x0000, busy=0.
2. Allocate:
   - write=1, write_key=0x0013, write_val=0x0040, hit=1 for one cycle.
   - Next cycle read_key=0x0013 -> read_valid=1, read_val=0x0040.
   - In the write cycle itself the same read shows read_valid=0.
3. Counter saturation:
   - From state 2, one not-taken update to 0x0013 -> read_valid=0.
   - Two taken updates -> read_valid=1 (ctr 11); a third taken keeps 11.
   - Four not-taken -> ctr 00, read_valid=0; one taken -> ctr 01, read_valid=0.
4. Alias replacement:
   - Entry 0x0013 valid. Read 0x0023 -> read_valid=0.
   - Write 0x0023 with target 0x0080, hit=1.
   - Then read 0x0023 -> valid, 0x0080; read 0x0013 -> read_valid=0.
   - A not-taken write to 0x0033 leaves 0x0023 intact.
5. Clear sweep:
   - Populate keys 0x0000..0x000F, all taken. Pulse clear together with a write to 0x0001.
   - busy=1 for exactly 16 cycles; read_valid=0 throughout; writes issued mid-sweep have no effect.
   - Afterwards all 16 lookups miss.
6. Async reset mid-clear:
   - Pulse clear; drive reset low asynchronously during cycle 5 of the sweep.
   - busy=0 and read_valid=0 immediately, without waiting for a clock edge.
   - After release, state=IDLE and an allocate/read per scenario 2 works.
